// File: rtl/pipelined_cla_addsub.sv
// Purpose : pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES-bit slice per stage.
// Latency : STAGES cycles from input transfer to out_valid; one operation per cycle when flowing.
// Backpr. : stall = out_valid && !out_ready freezes every stage; in_ready = !stall (combinational).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake for A, B, cin, sub
//   A, B, cin, sub          operands; sub=1 inverts B (A-B needs cin=1)
//   out_valid/out_ready     result handshake
//   sum, cout, ovf, zero    registered result and flags; hold their value while out_valid=0
module pipelined_cla_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int GROUP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW = WIDTH / STAGES;   // slice width
   localparam int NG = SW / GROUP;       // lookahead groups per slice
   // Skewed B operand: stage k keeps the (STAGES-1-k) slices it has not yet consumed,
   // packed back to back in one triangular bus.
   localparam int BW = (STAGES > 1) ? SW * STAGES * (STAGES - 1) / 2 : 1;

   function automatic int boff(input int k);
      int o;
      o = 0;
      for (int j = 0; j < k; j++) o += (STAGES - 1 - j) * SW;
      return o;
   endfunction

   // Two-level CLA over one slice: bit P/G -> group P/G -> group carries -> bit carries.
   // Returns {carry out, sum}.
   function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic ci);
      logic [SW-1:0] p, g, c;
      logic [NG-1:0] gp, gg;
      logic [NG:0]   gc;
      logic          acc, pp;
      p = a ^ b;
      g = a & b;
      for (int j = 0; j < NG; j++) begin
         acc = 1'b0;
         pp  = 1'b1;
         for (int i = GROUP - 1; i >= 0; i--) begin
            acc = acc | (g[j*GROUP+i] & pp);
            pp  = pp & p[j*GROUP+i];
         end
         gg[j] = acc;
         gp[j] = pp;
      end
      // Second-level lookahead: each group carry is a flat sum of products over the groups below.
      gc[0] = ci;
      for (int j = 1; j <= NG; j++) begin
         acc = 1'b0;
         pp  = 1'b1;
         for (int i = j - 1; i >= 0; i--) begin
            acc = acc | (gg[i] & pp);
            pp  = pp & gp[i];
         end
         gc[j] = acc | (pp & ci);
      end
      for (int j = 0; j < NG; j++) begin
         for (int k = 0; k < GROUP; k++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = k - 1; i >= 0; i--) begin
               acc = acc | (g[j*GROUP+i] & pp);
               pp  = pp & p[j*GROUP+i];
            end
            c[j*GROUP+k] = acc | (pp & gc[j]);
         end
      end
      return {gc[NG], p ^ c};
   endfunction

   logic                           stall;
   logic [WIDTH-1:0]               beff;
   logic [STAGES-1:0]              v_q, v_d;
   logic [STAGES-1:0]              c_q, c_d;
   // w_q[k] = {A bits not yet summed, sum bits already produced}; becomes the full sum at the end.
   logic [STAGES-1:0][WIDTH-1:0]   w_q, w_d;
   logic [BW-1:0]                  b_q, b_d;
   logic                           ovf_q, ovf_d, zero_q, zero_d;

   assign beff  = B ^ {WIDTH{sub}};
   assign stall = v_q[STAGES-1] & ~out_ready;

   if (STAGES == 1) begin : g_nob
      assign b_d = 1'b0;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << (k * SW);
      logic [WIDTH-1:0] w_in;
      logic [SW-1:0]    a_s, b_s;
      logic             ci_s;
      logic [SW:0]      res;

      if (k == 0) begin : g_in
         assign w_in    = A;
         assign b_s     = beff[SW-1:0];
         assign ci_s    = cin;
         assign v_d[0]  = in_valid;
         if (STAGES > 1) begin : g_fwd
            assign b_d[boff(0) +: (STAGES-1)*SW] = beff[WIDTH-1:SW];
         end
      end else begin : g_mid
         assign w_in    = w_q[k-1];
         assign b_s     = b_q[boff(k-1) +: SW];
         assign ci_s    = c_q[k-1];
         assign v_d[k]  = v_q[k-1];
         if (k < STAGES - 1) begin : g_fwd
            assign b_d[boff(k) +: (STAGES-1-k)*SW] = b_q[boff(k-1)+SW +: (STAGES-1-k)*SW];
         end
      end

      assign a_s    = w_in[k*SW +: SW];
      assign res    = cla_slice(a_s, b_s, ci_s);
      assign c_d[k] = res[SW];
      assign w_d[k] = (w_in & ~MASK) | (WIDTH'(res[SW-1:0]) << (k * SW));

      if (k == STAGES - 1) begin : g_last
         // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
         assign ovf_d  = (res[SW-1] ^ a_s[SW-1] ^ b_s[SW-1]) ^ res[SW];
         assign zero_d = ~|w_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q    <= '0;
         c_q    <= '0;
         w_q    <= '0;
         b_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (!stall) begin
         v_q <= v_d;
         b_q <= b_d;
         // Data registers load only with a valid operation so the outputs keep their last result.
         for (int k = 0; k < STAGES; k++) begin
            if (v_d[k]) begin
               w_q[k] <= w_d[k];
               c_q[k] <= c_d[k];
            end
         end
         if (v_d[STAGES-1]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign in_ready  = ~stall;
   assign out_valid = v_q[STAGES-1];
   assign sum       = w_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Purpose : directed, table-driven check of pipelined_cla_addsub (32 bits, 2 stages).
// Latency : expects out_valid STAGES clock edges after the accepting edge.
// Backpr. : exercises out_ready stalls, streaming and reset while operations are in flight.
module tb_pipelined_cla_addsub;
   localparam int W = 32;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
   logic [W-1:0] A, B, sum;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   pipelined_cla_addsub #(.WIDTH(W), .STAGES(S), .GROUP(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   typedef struct {
      logic [31:0] a, b;
      logic        ci, sb;
      logic [31:0] s;
      logic        co, ov, z;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int i);
      A   = tv[i].a;
      B   = tv[i].b;
      cin = tv[i].ci;
      sub = tv[i].sb;
   endtask

   task automatic chk_res(input string nm, input int i);
      chk({nm, "_sum"},  sum,  tv[i].s);
      chk({nm, "_cout"}, {31'b0, cout}, {31'b0, tv[i].co});
      chk({nm, "_ovf"},  {31'b0, ovf},  {31'b0, tv[i].ov});
      chk({nm, "_zero"}, {31'b0, zero}, {31'b0, tv[i].z});
   endtask

   // Single isolated operation: result must show up exactly S edges after acceptance.
   task automatic run_one(input int i, input string nm);
      int n;
      @(negedge clk);
      drive(i);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end while (!out_valid && n < 8);
      chk({nm, "_lat"}, n, S);
      chk_res(nm, i);
   endtask

   initial begin
      int got, sent, stall_cnt, seen;
      logic [31:0] held;

      //         a             b             ci    sb    sum           co    ov    z
      tv[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
      tv[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tv[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      tv[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      tv[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      tv[5] = '{32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345679, 1'b0, 1'b0, 1'b0};
      tv[6] = '{32'h00000003, 32'h00000003, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tv[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      tv[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      tv[9] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

      // Reset state.
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_sum", sum, 32'd0);
      chk("rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Isolated vectors.
      for (int i = 0; i < 10; i++) run_one(i, $sformatf("vec%0d", i));

      // Back-to-back stream of 8: results consecutive, in order, 2 cycles after each input.
      got = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            chk_res($sformatf("st%0d", got), got);
            chk("st_slot", cyc, got + S);
            got++;
         end
         if (cyc < 8) begin
            drive(cyc);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("st_count", got, 8);

      // Backpressure: out_ready low for 3 cycles while results are pending.
      got = 0; sent = 0; stall_cnt = 0; held = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc <= 5);
         if (sent < 6) begin
            drive(sent);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            if (stall_cnt > 0) chk("bp_hold", sum, held);
            held = sum;
            stall_cnt++;
         end
         if (out_valid && out_ready) begin
            chk_res($sformatf("bp%0d", got), got);
            got++;
         end
         if (in_valid && in_ready) sent++;
      end
      chk("bp_count", got, 6);
      chk("bp_stalls", stall_cnt, 3);
      @(negedge clk);
      in_valid = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("bp_no_dup", seen, 0);

      // Reset with two operations in flight (held by a stall).
      @(negedge clk);
      out_ready = 1'b0;
      drive(0);
      in_valid = 1'b1;
      @(negedge clk);
      drive(1);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_sum", sum, 32'd0);
      chk("mid_rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mid_rst_ghost", seen, 0);
      run_one(3, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the combinational 16-bit CLA adder.
- Operand width (WIDTH) is split into STAGES equal slices. Each slice is a hierarchical 4-bit-group CLA with one register stage, and the carry is passed between stages in registers.
- Supports add/subtract mode, cin chaining, status flags and valid/ready flow control.
- Sits in the datapath as the ALU's add/sub unit. Fully registered for timing closure at wide widths.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of 4*STAGES. Default build: 2 slices of 16 bits.
- STAGES, 2: number of pipeline stages, ≥1. Equals the latency in cycles.
- GROUP, 4: bits per lookahead group inside a slice. Fixed at 4; a second-level lookahead unit spans groups.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid, input, 1: operand set on A/B/cin/sub is valid.
- in_ready, output, 1: block can accept an operand set this cycle.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- cin, input, 1: carry-in.
- sub, input, 1: 0 = A+B+cin; 1 = A+~B+cin. With cin=1 this gives A−B.
- out_valid, output, 1: result outputs are valid.
- out_ready, input, 1: downstream accepts the result this cycle.
- sum, output, WIDTH: result.
- cout, output, 1: carry out of MSB. In sub mode, 1 means no borrow.
- ovf, output, 1: two's-complement signed overflow.
- zero, output, 1: sum == 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All stage valid bits, out_valid, sum, cout, ovf, zero clear to 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; no result for them ever appears.
- Operand preprocessing in stage 0: Beff = sub ? ~B : B. Carry into slice 0 is cin.
- Slice k (k=0..STAGES−1) covers bits [(k+1)*W/STAGES−1 : k*W/STAGES].
  - Stage k computes slice k from the registered operand copy and the registered carry from stage k−1.
  - Within a slice: 4-bit groups produce group P/G; a lookahead unit forms the group carries C4, C8, …; sum bit = P^carry.
- Skew: operand slices not yet consumed travel down the pipeline in registers. Sum slices already computed also travel in registers until the final stage.
- Latency: an operand accepted at edge n has its result on the outputs after edge n+STAGES. out_valid is high from then until the result is accepted.
- Throughput: one operation per cycle when not stalled.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready. The whole pipeline freezes on stall: no register updates and valid bits hold.
  - in_ready = !stall; it is combinational from out_ready.
  - Bubbles propagate with valid=0.
  - sum/flags hold stable while out_valid && !out_ready.
- Flags, all registered with sum:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- Outputs when out_valid=0: sum/flags keep their last value. Only out_valid is meaningful.
- Simultaneous accept and deliver in the same cycle is legal; both transfers occur.
- STAGES=1 degenerates to a single registered CLA with latency 1.
- Width arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- Reset, then A=0x0000FFFF, B=0x00000001, cin=0, sub=0, out_ready=1 → 2 cycles later: sum=0x00010000, cout=0, ovf=0, zero=0. Exercises the inter-stage carry.
- A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 → sum=0x00000000, cout=1, zero=1, ovf=0.
- Subtract: A=5, B=7, cin=1, sub=1 → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then A=0x80000000, B=1, cin=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Back-to-back stream of 8 operations with in_valid=1 and out_ready=1 → 8 consecutive out_valid cycles, results in order, first result 2 cycles after the first accept.
- Backpressure: hold out_ready=0 for 3 cycles with a result pending → in_ready=0 for those cycles; sum stable; no operation lost or duplicated. After out_ready=1 the queued results emerge in order.
- Assert rst_n=0 for one cycle while 2 operations are in flight → out_valid=0 and the flags cleared the next cycle; neither dropped result ever appears; a new operation after reset completes normally.
